// File: rtl/trig_out_event_agg.sv
// Event aggregator: edge-detects user event lines into sticky pending/overflow status
// and rate-limited TriggerOut pulses. Optional macro: TRIG_OUT_EVENT_AGG_OVF_PULSE_EN.

module trig_out_event_agg_lane (
  input  logic sys_clk,
  input  logic reset,
  input  logic evt,
  input  logic mask,
  input  logic ack,
  input  logic load,
  output logic pending,
  output logic overflow,
  output logic fresh
);
  logic prev, rise, ovf_set, fresh_set;

  assign rise    = evt & ~prev & mask;
  assign ovf_set = rise & pending & ~ack;
`ifdef TRIG_OUT_EVENT_AGG_OVF_PULSE_EN
  assign fresh_set = rise | ovf_set;
`else
  assign fresh_set = rise;
`endif

  // load hands fresh to the trigger register; a same-cycle rise survives for the next pulse
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      prev     <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      fresh    <= 1'b0;
    end else begin
      prev     <= evt;
      pending  <= rise | (pending & ~ack);
      overflow <= ~ack & (overflow | ovf_set);
      fresh    <= fresh_set | (fresh & ~load);
    end
  end
endmodule

module trig_out_event_agg #(
  parameter int N       = 16,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [N-1:0]     evt_in,
  input  logic [N-1:0]     evt_mask,
  input  logic [N-1:0]     evt_ack,
  output logic [N-1:0]     ep_trigger,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overflow,
  output logic [CNT_W-1:0] fire_count,
  output logic             busy
);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  fresh;
  logic          launch;

  for (genvar i = 0; i < N; i++) begin : g_lane
    trig_out_event_agg_lane u_lane (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .evt      (evt_in[i]),
      .mask     (evt_mask[i]),
      .ack      (evt_ack[i]),
      .load     (launch),
      .pending  (pending[i]),
      .overflow (overflow[i]),
      .fresh    (fresh[i])
    );
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    case (state)
      IDLE: if (|fresh) begin
        launch    = 1'b1;
        state_nxt = FIRE;
      end
      FIRE: begin
        state_nxt = HOLD;
        cnt_nxt   = HW'(HOLDOFF - 1);
      end
      HOLD: begin
        if (cnt == '0) begin
          if (|fresh) begin
            launch    = 1'b1;
            state_nxt = FIRE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ep_trigger <= '0;
      fire_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ep_trigger <= launch ? fresh : '0;
      if (launch && (fire_count != '1))
        fire_count <= fire_count + 1'b1;
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_trig_out_event_agg.sv
// Randomized and directed bench for trig_out_event_agg against a timestamp-based reference model.
module tb_trig_out_event_agg;
  localparam int N = 16, H = 4, CW = 10;
  localparam int FC_MAX = (1 << CW) - 1;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  evt_in = '0, evt_mask = '1, evt_ack = '0;
  logic [N-1:0]  ep_trigger, pending, overflow;
  logic [CW-1:0] fire_count;
  logic          busy;

  int n_tests = 0, n_fail = 0;

  // reference model: pulses scheduled by timestamp of the last fire
  logic [N-1:0] m_prev, m_pend, m_ovf, m_fresh, m_trig;
  int  m_fc, m_last, cyc;
  bit  m_fired, m_busy;

  trig_out_event_agg #(.N(N), .HOLDOFF(H), .CNT_W(CW)) dut (
    .sys_clk(sys_clk), .reset(reset), .evt_in(evt_in), .evt_mask(evt_mask),
    .evt_ack(evt_ack), .ep_trigger(ep_trigger), .pending(pending),
    .overflow(overflow), .fire_count(fire_count), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic void m_reset();
    m_prev = '0; m_pend = '0; m_ovf = '0; m_fresh = '0; m_trig = '0;
    m_fc = 0; m_last = 0; m_fired = 0; m_busy = 0;
  endfunction

  task automatic step();
    logic [N-1:0] rise, novf;
    @(posedge sys_clk);
    cyc++;
    if (reset) m_reset();
    else begin
      rise   = evt_in & ~m_prev & evt_mask;
      m_prev = evt_in;
      novf   = rise & m_pend & ~evt_ack;
      m_ovf  = (m_ovf | novf) & ~evt_ack;
      m_pend = (m_pend | rise) & ~(evt_ack & ~rise);
      if (m_fresh != 0 && (!m_fired || cyc - m_last >= H + 1)) begin
        m_trig = m_fresh; m_fresh = rise; m_last = cyc; m_fired = 1;
        if (m_fc < FC_MAX) m_fc++;
      end else begin
        m_trig = '0; m_fresh |= rise;
      end
      m_busy = m_fired && (cyc - m_last <= H);
    end
    #1;
  endtask

  task automatic settle(input logic [N-1:0] ack_bits);
    evt_in = '0; evt_ack = ack_bits; step(); evt_ack = '0;
    repeat (H + 3) step();
  endtask

  task automatic test_reset();
    m_reset();
    repeat (2) step();
    n_tests++;
    if ({ep_trigger, pending, overflow, fire_count, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state trig=%h pend=%h ovf=%h fc=%0d busy=%b expected all 0",
               ep_trigger, pending, overflow, fire_count, busy);
    end
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_single();
    evt_in = 16'h0008; step();
    n_tests++;
    if (pending !== 16'h0008 || ep_trigger !== 16'h0) begin
      n_fail++; $display("FAIL single_latency pend=%h trig=%h expected 0008/0000", pending, ep_trigger);
    end
    step();
    n_tests++;
    if (ep_trigger !== 16'h0008 || fire_count !== 10'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_pulse trig=%h fc=%0d busy=%b expected 0008/1/1", ep_trigger, fire_count, busy);
    end
    step();
    n_tests++;
    if (ep_trigger !== 16'h0) begin
      n_fail++; $display("FAIL single_width trig=%h expected 0000", ep_trigger);
    end
    settle(16'h0008);
    n_tests++;
    if (pending !== 16'h0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_ack pend=%h busy=%b expected 0000/0", pending, busy);
    end
  endtask

  task automatic test_spacing();
    evt_in = 16'h0001; step();
    step();
    n_tests++;
    if (ep_trigger !== 16'h0001) begin
      n_fail++; $display("FAIL spacing_first trig=%h expected 0001", ep_trigger);
    end
    evt_in = 16'h0021; step();
    for (int i = 0; i < H - 1; i++) begin
      step();
      n_tests++;
      if (ep_trigger !== 16'h0) begin
        n_fail++; $display("FAIL spacing_gap%0d trig=%h expected 0000", i, ep_trigger);
      end
    end
    step();
    n_tests++;
    if (ep_trigger !== 16'h0020 || fire_count !== CW'(m_fc)) begin
      n_fail++; $display("FAIL spacing_second trig=%h fc=%0d expected 0020/%0d", ep_trigger, fire_count, m_fc);
    end
    settle(16'h0021);
  endtask

  task automatic test_overflow();
    evt_in = 16'h0004; step();
    evt_in = 16'h0000; step();
    evt_in = 16'h0004; step();
    n_tests++;
    if (overflow !== 16'h0004 || pending !== 16'h0004) begin
      n_fail++; $display("FAIL ovf_set ovf=%h pend=%h expected 0004/0004", overflow, pending);
    end
    evt_ack = 16'h0004; step(); evt_ack = '0;
    n_tests++;
    if (pending[2] !== 1'b0 || overflow[2] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_ack pend2=%b ovf2=%b expected 0/0", pending[2], overflow[2]);
    end
    settle('0);
  endtask

  task automatic test_mask();
    evt_mask = 16'hFFFE; evt_in = 16'h0001;
    for (int i = 0; i < H + 3; i++) begin
      step();
      n_tests++;
      if (ep_trigger !== 16'h0 || pending[0] !== 1'b0) begin
        n_fail++; $display("FAIL mask_block%0d trig=%h pend0=%b expected 0000/0", i, ep_trigger, pending[0]);
      end
    end
    evt_in = '0; step();
    evt_mask = '1;
    evt_in = 16'h0002; step();
    evt_in = 16'h0000; step();
    evt_in = 16'h0002; evt_ack = 16'h0002; step(); evt_ack = '0;
    n_tests++;
    if (pending[1] !== 1'b1 || overflow[1] !== 1'b0) begin
      n_fail++; $display("FAIL rise_ack_same pend1=%b ovf1=%b expected 1/0", pending[1], overflow[1]);
    end
    settle(16'h0002);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6000; i++) begin
      evt_in = evt_in ^ 16'h0200; step();
    end
    n_tests++;
    if (fire_count !== CW'(FC_MAX) || m_fc != FC_MAX) begin
      n_fail++; $display("FAIL fire_count_sat fc=%0d expected %0d", fire_count, FC_MAX);
    end
    settle(16'h0200);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      evt_in   = N'($urandom);
      evt_mask = N'($urandom) | 16'hF0F0;
      evt_ack  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step();
      n_tests++;
      if ({ep_trigger, pending, overflow, fire_count, busy} !==
          {m_trig, m_pend, m_ovf, CW'(m_fc), m_busy}) begin
        n_fail++;
        $display("FAIL random%0d trig=%h/%h pend=%h/%h ovf=%h/%h fc=%0d/%0d busy=%b/%b (got/expected)",
                 i, ep_trigger, m_trig, pending, m_pend, overflow, m_ovf, fire_count, m_fc, busy, m_busy);
      end
    end
    evt_mask = '1;
    settle('1);
  endtask

  task automatic test_reset_mid_hold();
    evt_in = 16'h0100; step();
    step();
    step();
    evt_in = 16'h01FF; step();
    n_tests++;
    if (busy !== 1'b1 || m_fresh !== 16'h00FF) begin
      n_fail++; $display("FAIL hold_setup busy=%b expected 1", busy);
    end
    reset = 1'b1; #1;
    n_tests++;
    if ({ep_trigger, pending, overflow, fire_count, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_hold trig=%h pend=%h ovf=%h fc=%0d busy=%b expected all 0",
               ep_trigger, pending, overflow, fire_count, busy);
    end
    m_reset();
    evt_in = 16'h0080; #1 reset = 1'b0;
    step();
    n_tests++;
    if (pending !== 16'h0080 || ep_trigger !== 16'h0) begin
      n_fail++; $display("FAIL post_reset_rise pend=%h trig=%h expected 0080/0000", pending, ep_trigger);
    end
    step();
    n_tests++;
    if (ep_trigger !== 16'h0080 || fire_count !== 10'd1) begin
      n_fail++; $display("FAIL post_reset_pulse trig=%h fc=%0d expected 0080/1", ep_trigger, fire_count);
    end
  endtask

  initial begin
    cyc = 0;
    #1;
    test_reset();
    test_single();
    test_spacing();
    test_overflow();
    test_mask();
    test_saturation();
    test_random();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trig_out_event_agg.md
Name: trig_out_event_agg

Overview:
- Collects user-logic event lines (counter wrap, threshold crossings, FIFO flags) into a host-visible trigger set, on the FPGA-to-host side of the trigger path.
- Drives a TriggerOut endpoint with one-cycle pulses and keeps sticky pending/overflow status for WireOut readback.
- Host acknowledgements arrive as one-cycle TriggerIn pulses and clear the status.
- A holdoff state machine rate-limits and coalesces bursts so host polling never misses an event.

Parameters:
N, 16, number of event lines (1..32)
HOLDOFF, 16, minimum idle cycles after a trigger pulse before the next one (>=1)
CNT_W, 16, width of the fire counter

Ports:
sys_clk  input  1  sole clock; all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
evt_in  input  N  event levels from user logic, synchronous to sys_clk
evt_mask  input  N  1 = event line enabled (from a WireIn)
evt_ack  input  N  one-cycle acknowledge pulses per bit (from a TriggerIn)
ep_trigger  output  N  one-cycle trigger bits to the TriggerOut endpoint, registered
pending  output  N  sticky: event seen and not yet acknowledged
overflow  output  N  sticky: repeat event while pending already set
fire_count  output  CNT_W  number of trigger pulses issued, saturating
busy  output  1  high when FSM is not IDLE

Behaviour:
- Reset values: ep_trigger=0, pending=0, overflow=0, fire_count=0, busy=0, evt_prev=0, fresh=0, FSM=IDLE, holdoff counter=0.
- Edge detect: rise = evt_in & ~evt_prev & evt_mask; evt_prev <= evt_in every cycle.
  - A line already high at the first edge after reset counts as a rise.
  - Only rising edges count; level-high does not retrigger.
- Mask: clearing a mask bit blocks new rises only; it does not clear pending, overflow or fresh for that bit.
- pending[i]:
  - set on rise[i].
  - cleared on evt_ack[i] when rise[i] is 0.
  - rise and ack in the same cycle: pending stays 1.
- overflow[i]:
  - set on rise[i] when pending[i]==1 and evt_ack[i]==0.
  - cleared on evt_ack[i], including a same-cycle rise.
  - ack has priority over a new overflow.
- fresh[i] (internal): set on rise[i]; marks an event not yet sent in a trigger pulse.
- FSM states:
  - IDLE: if |fresh, go to FIRE and load ep_trigger <= fresh. Rises in that same cycle stay in fresh for the next pulse. All other fresh bits clear.
  - FIRE (1 cycle, ep_trigger valid): go to HOLD; ep_trigger <= 0; holdoff counter <= HOLDOFF-1.
  - HOLD: counter decrements each cycle.
    - At counter 0 with |fresh: go to FIRE and load ep_trigger as in IDLE.
    - At counter 0 with no fresh: go to IDLE.
- Latency: rise sampled at edge k, then pending/fresh high after edge k, then ep_trigger high for exactly one cycle after edge k+1 (from IDLE).
- Spacing: minimum rising-edge spacing between successive ep_trigger pulses is HOLDOFF+1 cycles. Events arriving during FIRE/HOLD coalesce into one pulse.
- fire_count increments on each FIRE entry and saturates at all-ones (no wrap).
- busy = (state != IDLE).
- Reset asserted mid-HOLD or mid-FIRE: immediate return to reset values; no partial pulse.
- evt_ack has no effect on fresh or the FSM; acknowledge and trigger paths are independent.

Optional Feature:
TRIG_OUT_EVENT_AGG_OVF_PULSE_EN
- Defined: a new overflow on bit i also sets fresh[i], so repeat events produce another trigger pulse after holdoff.
- Undefined: a repeat rise while pending is recorded in overflow only. fresh is still set per the base rule, since every rise sets fresh; overflow adds no extra set.
- Ports are identical in both builds.

Test Plan:
- Reset, N=16, HOLDOFF=4, mask=0xFFFF; pulse evt_in[3] 0->1 at edge 10 -> ep_trigger=0x0008 for one cycle after edge 11; pending=0x0008; fire_count=1.
- evt_in[0] rise at edge 10, evt_in[5] rise at edge 12 (in HOLD) -> pulses 0x0001 at cycle 11 and 0x0020 at cycle 16 (spacing 5); fire_count=2.
- Bit 2 rises twice with no ack -> overflow=0x0004. evt_ack=0x0004 with no rise -> pending[2]=0, overflow[2]=0 next cycle.
- mask=0xFFFE with evt_in[0] rise -> no pulse, pending=0. Then rise and ack on bit 1 in the same cycle after a prior pending -> pending[1] stays 1, overflow[1]=0.
- Force 2^16+3 fires with CNT_W=16 -> fire_count holds 0xFFFF.
- Assert reset during HOLD with fresh=0x00FF -> all outputs 0 immediately. After release with evt_in[7] held high -> a rise is detected and a pulse of 0x0080 follows.
